// File: rtl/riscv_params_pkg.sv
// Shared constants and types for the simple_RISC pipeline.
//   - Opcode constants for the SimpleRisc ISA (ADD .. RET, NOP = 5'b01101).
//   - RA_IDX: return-address register used by call/ret.
//   - decoded_instr_t: payload of the ID/EX pipeline register.
//   - Helpers for the bubble value and immediate extension.
package riscv_params_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned NUM_REGS    = 16;
  localparam int unsigned REG_IDX_W   = 4;

  localparam logic [REG_IDX_W-1:0] RA_IDX = 4'd15;

  localparam logic [4:0] ADD  = 5'b00000;
  localparam logic [4:0] SUB  = 5'b00001;
  localparam logic [4:0] MUL  = 5'b00010;
  localparam logic [4:0] DIV  = 5'b00011;
  localparam logic [4:0] MOD  = 5'b00100;
  localparam logic [4:0] CMP  = 5'b00101;
  localparam logic [4:0] AND  = 5'b00110;
  localparam logic [4:0] OR   = 5'b00111;
  localparam logic [4:0] NOT  = 5'b01000;
  localparam logic [4:0] MOV  = 5'b01001;
  localparam logic [4:0] LSL  = 5'b01010;
  localparam logic [4:0] LSR  = 5'b01011;
  localparam logic [4:0] ASR  = 5'b01100;
  localparam logic [4:0] NOP  = 5'b01101;
  localparam logic [4:0] LD   = 5'b01110;
  localparam logic [4:0] ST   = 5'b01111;
  localparam logic [4:0] BEQ  = 5'b10000;
  localparam logic [4:0] BGT  = 5'b10001;
  localparam logic [4:0] B    = 5'b10010;
  localparam logic [4:0] CALL = 5'b10011;
  localparam logic [4:0] RET  = 5'b10100;

  typedef struct packed {
    logic                   valid;
    logic [INSTR_WIDTH-1:0] pc;
    logic [4:0]             opcode;
    logic [REG_IDX_W-1:0]   rd;
    logic [REG_IDX_W-1:0]   rs1;
    logic [REG_IDX_W-1:0]   rs2;
    logic [INSTR_WIDTH-1:0] op1;
    logic [INSTR_WIDTH-1:0] op2;
    logic [INSTR_WIDTH-1:0] st_data;
    logic [INSTR_WIDTH-1:0] branch_target;
    logic                   is_ld;
    logic                   is_st;
    logic                   is_branch;
    logic                   wb_en;
  } decoded_instr_t;

  // Empty ID/EX slot: everything zero except the opcode, which reads as NOP.
  function automatic decoded_instr_t bubble_instr();
    decoded_instr_t b;
    b        = '0;
    b.opcode = NOP;
    return b;
  endfunction

  // Modifier 11 is not defined by the ISA and falls back to sign extension.
  function automatic logic [INSTR_WIDTH-1:0] ext_imm(input logic [1:0]  modifier,
                                                     input logic [15:0] imm16);
    logic [INSTR_WIDTH-1:0] r;
    unique case (modifier)
      2'b01:   r = {16'h0000, imm16};
      2'b10:   r = {imm16, 16'h0000};
      default: r = {{16{imm16[15]}}, imm16};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 16x32 architectural register file.
//   clk, rst          : clock, synchronous active-high reset (zeroes every register).
//   rd_addr_*_i       : three asynchronous read ports (a, b, c).
//   rd_data_*_o       : read data; returns wr_data_i when reading the register being written.
//   wr_en_i/addr/data : one synchronous write port. r0 is an ordinary register.
module reg_file
  import riscv_params_pkg::*;
#(
  parameter int unsigned NumRegs = NUM_REGS,
  parameter int unsigned Width   = INSTR_WIDTH,
  parameter int unsigned AddrW   = $clog2(NumRegs)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AddrW-1:0] rd_addr_a_i,
  input  logic [AddrW-1:0] rd_addr_b_i,
  input  logic [AddrW-1:0] rd_addr_c_i,
  output logic [Width-1:0] rd_data_a_o,
  output logic [Width-1:0] rd_data_b_o,
  output logic [Width-1:0] rd_data_c_o,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [Width-1:0] wr_data_i
);

  logic [Width-1:0] regs_q [NumRegs];
  logic [Width-1:0] regs_d [NumRegs];

  always_comb begin
    regs_d = regs_q;
    if (rst) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        regs_d[i] = '0;
      end
    end else if (wr_en_i) begin
      regs_d[wr_addr_i] = wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  // Write-through bypass so decode sees a value being written back this cycle.
  always_comb begin
    rd_data_a_o = (wr_en_i && wr_addr_i == rd_addr_a_i) ? wr_data_i : regs_q[rd_addr_a_i];
    rd_data_b_o = (wr_en_i && wr_addr_i == rd_addr_b_i) ? wr_data_i : regs_q[rd_addr_b_i];
    rd_data_c_o = (wr_en_i && wr_addr_i == rd_addr_c_i) ? wr_data_i : regs_q[rd_addr_c_i];
  end

endmodule

// File: rtl/decode_unit.sv
// Decode stage of the simple_RISC core.
//   Inputs : clk, rst (sync, active-high), in_pc (instr addr + 4), in_instr, flush (taken
//            branch from EX), wb_en/wb_rd/wb_data (register-file write from writeback).
//   Outputs: stall (combinational load-use hazard, fetch_en = !stall) and the ID/EX
//            register: out_valid, out_pc, out_opcode, out_rd/rs1/rs2, out_op1, out_op2,
//            out_st_data, out_branch_target, out_is_ld, out_is_st, out_is_branch, out_wb_en.
module decode_unit
  import riscv_params_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] in_pc,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  input  logic                   flush,
  input  logic                   wb_en,
  input  logic [REG_IDX_W-1:0]   wb_rd,
  input  logic [INSTR_WIDTH-1:0] wb_data,
  output logic                   stall,
  output logic                   out_valid,
  output logic [INSTR_WIDTH-1:0] out_pc,
  output logic [4:0]             out_opcode,
  output logic [REG_IDX_W-1:0]   out_rd,
  output logic [REG_IDX_W-1:0]   out_rs1,
  output logic [REG_IDX_W-1:0]   out_rs2,
  output logic [INSTR_WIDTH-1:0] out_op1,
  output logic [INSTR_WIDTH-1:0] out_op2,
  output logic [INSTR_WIDTH-1:0] out_st_data,
  output logic [INSTR_WIDTH-1:0] out_branch_target,
  output logic                   out_is_ld,
  output logic                   out_is_st,
  output logic                   out_is_branch,
  output logic                   out_wb_en
);

  logic [4:0]             opcode;
  logic                   i_bit;
  logic [REG_IDX_W-1:0]   rd_idx;
  logic [REG_IDX_W-1:0]   rs1_idx;
  logic [REG_IDX_W-1:0]   rs2_idx;
  logic [INSTR_WIDTH-1:0] rs1_val;
  logic [INSTR_WIDTH-1:0] rs2_val;
  logic [INSTR_WIDTH-1:0] rd_val;
  logic [INSTR_WIDTH-1:0] imm_val;
  logic [INSTR_WIDTH-1:0] offset_val;
  logic                   rs1_live;
  logic                   rs2_live;
  logic                   rd_live;
  logic                   hazard_match;
  decoded_instr_t         dec;
  decoded_instr_t         id_ex_d;
  decoded_instr_t         id_ex_q;

  assign opcode = in_instr[31:27];
  assign i_bit  = in_instr[26];

  // call/ret implicitly use the return-address register.
  always_comb begin
    rd_idx  = in_instr[25:22];
    rs1_idx = in_instr[21:18];
    rs2_idx = in_instr[17:14];
    if (opcode == RET)  rs1_idx = RA_IDX;
    if (opcode == CALL) rd_idx  = RA_IDX;
  end

  reg_file u_reg_file (
    .clk         (clk),
    .rst         (rst),
    .rd_addr_a_i (rs1_idx),
    .rd_addr_b_i (rs2_idx),
    .rd_addr_c_i (rd_idx),
    .rd_data_a_o (rs1_val),
    .rd_data_b_o (rs2_val),
    .rd_data_c_o (rd_val),
    .wr_en_i     (wb_en),
    .wr_addr_i   (wb_rd),
    .wr_data_i   (wb_data)
  );

  assign imm_val    = ext_imm(in_instr[17:16], in_instr[15:0]);
  // Word offset: sign-extend the 27-bit field and scale by 4.
  assign offset_val = {{3{in_instr[26]}}, in_instr[26:0], 2'b00};

  always_comb begin
    dec               = '0;
    dec.valid         = 1'b1;
    dec.pc            = in_pc - 32'd4;
    dec.opcode        = opcode;
    dec.rd            = rd_idx;
    dec.rs1           = rs1_idx;
    dec.rs2           = rs2_idx;
    dec.op1           = rs1_val;
    dec.op2           = i_bit ? imm_val : rs2_val;
    dec.st_data       = rd_val;
    dec.branch_target = dec.pc + offset_val;
    dec.is_ld         = (opcode == LD);
    dec.is_st         = (opcode == ST);
    dec.is_branch     = opcode inside {BEQ, BGT, B, CALL, RET};
    dec.wb_en         = !(opcode inside {CMP, NOP, ST, BEQ, BGT, B, RET});
  end

  // Source registers that are actually read by the instruction in decode.
  // The rs2 range ADD..ASR covers every register-form ALU op, cmp included.
  always_comb begin
    rs1_live     = !(opcode inside {NOP, MOV, NOT, B, CALL});
    rs2_live     = !i_bit && (opcode inside {[ADD:ASR]});
    rd_live      = (opcode == ST);
    hazard_match = (rs1_live && (id_ex_q.rd == rs1_idx)) ||
                   (rs2_live && (id_ex_q.rd == rs2_idx)) ||
                   (rd_live  && (id_ex_q.rd == rd_idx));
  end

  assign stall = !flush && id_ex_q.valid && id_ex_q.is_ld && id_ex_q.wb_en && hazard_match;

  always_comb begin
    id_ex_d = dec;
    if (rst || flush || stall) begin
      id_ex_d = bubble_instr();
    end
  end

  always_ff @(posedge clk) begin
    id_ex_q <= id_ex_d;
  end

  assign out_valid         = id_ex_q.valid;
  assign out_pc            = id_ex_q.pc;
  assign out_opcode        = id_ex_q.opcode;
  assign out_rd            = id_ex_q.rd;
  assign out_rs1           = id_ex_q.rs1;
  assign out_rs2           = id_ex_q.rs2;
  assign out_op1           = id_ex_q.op1;
  assign out_op2           = id_ex_q.op2;
  assign out_st_data       = id_ex_q.st_data;
  assign out_branch_target = id_ex_q.branch_target;
  assign out_is_ld         = id_ex_q.is_ld;
  assign out_is_st         = id_ex_q.is_st;
  assign out_is_branch     = id_ex_q.is_branch;
  assign out_wb_en         = id_ex_q.wb_en;

endmodule

// File: tb/tb_decode_unit.sv
// Directed bench for decode_unit: one task per scenario, inline comparisons.
module tb_decode_unit;
  import riscv_params_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [4:0]  out_opcode;
  logic [3:0]  out_rd;
  logic [3:0]  out_rs1;
  logic [3:0]  out_rs2;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [31:0] out_st_data;
  logic [31:0] out_branch_target;
  logic        out_is_ld;
  logic        out_is_st;
  logic        out_is_branch;
  logic        out_wb_en;

  int checks = 0;
  int errors = 0;

  decode_unit dut (
    .clk               (clk),
    .rst               (rst),
    .in_pc             (in_pc),
    .in_instr          (in_instr),
    .flush             (flush),
    .wb_en             (wb_en),
    .wb_rd             (wb_rd),
    .wb_data           (wb_data),
    .stall             (stall),
    .out_valid         (out_valid),
    .out_pc            (out_pc),
    .out_opcode        (out_opcode),
    .out_rd            (out_rd),
    .out_rs1           (out_rs1),
    .out_rs2           (out_rs2),
    .out_op1           (out_op1),
    .out_op2           (out_op2),
    .out_st_data       (out_st_data),
    .out_branch_target (out_branch_target),
    .out_is_ld         (out_is_ld),
    .out_is_st         (out_is_st),
    .out_is_branch     (out_is_branch),
    .out_wb_en         (out_wb_en)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [4:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, 1'b0, rd, rs1, rs2, 14'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [1:0] md,
                                        input logic [15:0] imm);
    return {op, 1'b1, rd, rs1, md, imm};
  endfunction

  function automatic logic [31:0] enc_b(input logic [4:0] op, input logic [26:0] off);
    return {op, off};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_pc = 32'd4; in_instr = enc_b(NOP, 27'd0); flush = 1'b0;
    wb_en = 1'b0; wb_rd = 4'd0; wb_data = 32'd0;
    tick(); tick();
    rst = 1'b0; wb_en = 1'b1; wb_rd = 4'd2; wb_data = 32'h55;
    tick();
    wb_en = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %0d want 0", out_valid);
    end
    checks++;
    if (out_opcode !== NOP) begin
      errors++; $display("FAIL reset_opcode got %b want %b", out_opcode, NOP);
    end
    checks++;
    if (stall !== 1'b0 || out_wb_en !== 1'b0 || out_is_ld !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got stall=%0d wb=%0d ld=%0d want 0 0 0",
                         stall, out_wb_en, out_is_ld);
    end
    in_instr = enc_r(ADD, 4'd1, 4'd2, 4'd3);
    tick();
    checks++;
    if (out_op1 !== 32'd0) begin
      errors++; $display("FAIL reset_regfile got %h want 0", out_op1);
    end
  endtask

  task automatic test_add();
    in_instr = enc_b(NOP, 27'd0);
    wb_en = 1'b1; wb_rd = 4'd2; wb_data = 32'd5;
    tick();
    wb_rd = 4'd3; wb_data = 32'd7;
    tick();
    wb_en = 1'b0;
    in_pc = 32'h8; in_instr = enc_r(ADD, 4'd1, 4'd2, 4'd3);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_op1 !== 32'd5 || out_op2 !== 32'd7) begin
      errors++; $display("FAIL add_ops got v=%0d op1=%0d op2=%0d want 1 5 7",
                         out_valid, out_op1, out_op2);
    end
    checks++;
    if (out_rd !== 4'd1 || out_wb_en !== 1'b1 || out_pc !== 32'h4) begin
      errors++; $display("FAIL add_ctrl got rd=%0d wb=%0d pc=%h want 1 1 4",
                         out_rd, out_wb_en, out_pc);
    end
  endtask

  task automatic test_imm();
    logic [1:0]  mods [4];
    logic [31:0] exp  [4];
    mods[0] = 2'b00; exp[0] = 32'hFFFF_FFFE;
    mods[1] = 2'b01; exp[1] = 32'h0000_FFFE;
    mods[2] = 2'b10; exp[2] = 32'hFFFE_0000;
    mods[3] = 2'b11; exp[3] = 32'hFFFF_FFFE;
    for (int i = 0; i < 4; i++) begin
      in_instr = enc_i(MOV, 4'd4, 4'd0, mods[i], 16'hFFFE);
      tick();
      checks++;
      if (out_op2 !== exp[i] || out_rd !== 4'd4) begin
        errors++; $display("FAIL imm_mod%0d got op2=%h rd=%0d want %h 4",
                           i, out_op2, out_rd, exp[i]);
      end
    end
  endtask

  task automatic test_load_use();
    in_pc = 32'h40; in_instr = enc_i(LD, 4'd5, 4'd6, 2'b00, 16'd0);
    tick();
    checks++;
    if (out_is_ld !== 1'b1 || out_wb_en !== 1'b1) begin
      errors++; $display("FAIL ld_ctrl got ld=%0d wb=%0d want 1 1", out_is_ld, out_wb_en);
    end
    in_pc = 32'h44; in_instr = enc_r(ADD, 4'd7, 4'd5, 4'd1);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL lu_stall got %0d want 1", stall);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_opcode !== NOP || stall !== 1'b0) begin
      errors++; $display("FAIL lu_bubble got v=%0d op=%b stall=%0d want 0 %b 0",
                         out_valid, out_opcode, stall, NOP);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_rs1 !== 4'd5 || out_opcode !== ADD) begin
      errors++; $display("FAIL lu_resume got v=%0d rs1=%0d op=%b want 1 5 %b",
                         out_valid, out_rs1, out_opcode, ADD);
    end
    // mov ignores rs1, so a matching rs1 field is no hazard.
    in_instr = enc_i(LD, 4'd5, 4'd6, 2'b00, 16'd0);
    tick();
    in_instr = enc_i(MOV, 4'd1, 4'd5, 2'b00, 16'd1);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL lu_mov_nostall got %0d want 0", stall);
    end
    // st reads rd as store data.
    in_instr = enc_i(LD, 4'd5, 4'd6, 2'b00, 16'd0);
    tick();
    in_instr = enc_i(ST, 4'd5, 4'd0, 2'b00, 16'd0);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL lu_st_stall got %0d want 1", stall);
    end
    // Reset while stalling drops the stall in the following cycle.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (stall !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL lu_reset got stall=%0d v=%0d want 0 0", stall, out_valid);
    end
  endtask

  task automatic test_branch();
    in_pc = 32'h20; in_instr = enc_b(B, 27'h7FF_FFFD);
    tick();
    checks++;
    if (out_pc !== 32'h1C || out_branch_target !== 32'h10) begin
      errors++; $display("FAIL b_target got pc=%h tgt=%h want 1c 10", out_pc, out_branch_target);
    end
    checks++;
    if (out_is_branch !== 1'b1 || out_wb_en !== 1'b0) begin
      errors++; $display("FAIL b_ctrl got br=%0d wb=%0d want 1 0", out_is_branch, out_wb_en);
    end
  endtask

  task automatic test_flush();
    in_instr = enc_i(LD, 4'd5, 4'd6, 2'b00, 16'd0);
    tick();
    in_instr = enc_r(ADD, 4'd7, 4'd5, 4'd1);
    flush = 1'b1; wb_en = 1'b1; wb_rd = 4'd9; wb_data = 32'hAB;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL flush_stall got %0d want 0", stall);
    end
    tick();
    flush = 1'b0; wb_en = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_opcode !== NOP || out_is_ld !== 1'b0) begin
      errors++; $display("FAIL flush_bubble got v=%0d op=%b ld=%0d want 0 %b 0",
                         out_valid, out_opcode, out_is_ld, NOP);
    end
    in_instr = enc_r(ADD, 4'd1, 4'd9, 4'd9);
    tick();
    checks++;
    if (out_op1 !== 32'hAB || out_op2 !== 32'hAB) begin
      errors++; $display("FAIL flush_wb got op1=%h op2=%h want ab ab", out_op1, out_op2);
    end
  endtask

  task automatic test_writethrough();
    in_instr = enc_r(SUB, 4'd3, 4'd2, 4'd2);
    wb_en = 1'b1; wb_rd = 4'd2; wb_data = 32'h1234;
    tick();
    wb_en = 1'b0;
    checks++;
    if (out_op1 !== 32'h1234 || out_op2 !== 32'h1234) begin
      errors++; $display("FAIL wt_ops got op1=%h op2=%h want 1234 1234", out_op1, out_op2);
    end
    in_instr = enc_b(RET, 27'd0);
    tick();
    checks++;
    if (out_rs1 !== 4'd15 || out_is_branch !== 1'b1 || out_wb_en !== 1'b0) begin
      errors++; $display("FAIL ret got rs1=%0d br=%0d wb=%0d want 15 1 0",
                         out_rs1, out_is_branch, out_wb_en);
    end
    in_pc = 32'h104; in_instr = enc_b(CALL, 27'd4);
    tick();
    checks++;
    if (out_rd !== 4'd15 || out_wb_en !== 1'b1 || out_branch_target !== 32'h110) begin
      errors++; $display("FAIL call got rd=%0d wb=%0d tgt=%h want 15 1 110",
                         out_rd, out_wb_en, out_branch_target);
    end
  endtask

  task automatic test_nop_store();
    in_instr = enc_b(NOP, 27'd0);
    wb_en = 1'b1; wb_rd = 4'd5; wb_data = 32'h77;
    tick();
    wb_en = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_wb_en !== 1'b0 || out_is_branch !== 1'b0) begin
      errors++; $display("FAIL nop got v=%0d wb=%0d br=%0d want 1 0 0",
                         out_valid, out_wb_en, out_is_branch);
    end
    in_instr = enc_i(ST, 4'd5, 4'd0, 2'b00, 16'd8);
    tick();
    checks++;
    if (out_is_st !== 1'b1 || out_st_data !== 32'h77 || out_wb_en !== 1'b0) begin
      errors++; $display("FAIL st got st=%0d data=%h wb=%0d want 1 77 0",
                         out_is_st, out_st_data, out_wb_en);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_load_use();
    test_branch();
    test_flush();
    test_writethrough();
    test_nop_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
